// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared definitions for the keypad matrix scanner.
//           - Key index constants for the standard 4x4 layout
//             (row 0: 1 2 3 A, row 1: 4 5 6 B, row 2: 7 8 9 C, row 3: * 0 # D)
//           - Gameplay action encoding consumed downstream of the scanner
//           - key_bit(): flat bit position of a key in the key vectors
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Key index k = r*COLS + c for the 4x4 layout.
  localparam int KEY_1    = 0;
  localparam int KEY_2    = 1;
  localparam int KEY_3    = 2;
  localparam int KEY_A    = 3;
  localparam int KEY_4    = 4;
  localparam int KEY_5    = 5;
  localparam int KEY_6    = 6;
  localparam int KEY_B    = 7;
  localparam int KEY_7    = 8;
  localparam int KEY_8    = 9;
  localparam int KEY_9    = 10;
  localparam int KEY_C    = 11;
  localparam int KEY_STAR = 12;
  localparam int KEY_0    = 13;
  localparam int KEY_HASH = 14;
  localparam int KEY_D    = 15;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_LEFT   = 3'd1,
    ACT_RIGHT  = 3'd2,
    ACT_ATTACK = 3'd3,
    ACT_SELECT = 3'd4
  } action_e;

  // Flat bit position of (pad,row,col) inside every key vector.
  function automatic int key_bit(input int pad, input int row, input int col,
                                 input int rows = 4, input int cols = 4);
    return pad * rows * cols + row * cols + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : keypad_key_debounce
// Purpose : Per-key debounce cell. The held state only changes after
//           DEBOUNCE_SCANS consecutive frame samples disagree with it; each
//           change produces a registered one-cycle press or release pulse.
// Ports   : clk_i      system clock
//           rst_i      synchronous active-high reset
//           upd_i      frame-end strobe, the only cycle the cell evaluates
//           sample_i   this key's sample from the completed frame (1=pressed)
//           state_o    debounced held state
//           press_o    1-cycle pulse, one cycle after state_o rises
//           release_o  1-cycle pulse, one cycle after state_o falls
// Revision: 1.0 - initial release
// ============================================================================
module keypad_key_debounce #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic upd_i,
  input  logic sample_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic             state_q, state_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, release_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (upd_i) begin
      if (sample_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = sample_i;
        cnt_d   = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pulses are derived from the registered state against its one-cycle
  // delayed copy, so they land one cycle after the state edge. Reset clears
  // both copies together, so a reset never looks like a release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= state_q;
      press_q   <= state_q & ~prev_q;
      release_q <= ~state_q & prev_q;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_matrix_scanner
// Purpose : Scans NUM_PADS active-low ROWSxCOLS keypads with a shared row
//           timebase, synchronises the column senses, assembles one sample
//           frame per full row sweep and debounces every key across frames.
// Ports   : clk_i          system clock
//           rst_i          synchronous active-high reset
//           scan_en_i      1 = scanning, 0 = rows released and states frozen
//           row_o          active-low row drive, pad p at [p*ROWS +: ROWS]
//           col_i          active-low async column sense, pad p at [p*COLS +: COLS]
//           key_state_o    debounced held state per key (1 = pressed)
//           key_press_o    1-cycle pulse per key on press
//           key_release_o  1-cycle pulse per key on release
//           frame_done_o   1-cycle pulse after the last row of a frame is sampled
//           any_key_o      per pad, OR of its key states (registered)
// Revision: 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_PADS       = 2,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scan_en_i,
  output logic [NUM_PADS*ROWS-1:0]      row_o,
  input  logic [NUM_PADS*COLS-1:0]      col_i,
  output logic [NUM_PADS*ROWS*COLS-1:0] key_state_o,
  output logic [NUM_PADS*ROWS*COLS-1:0] key_press_o,
  output logic [NUM_PADS*ROWS*COLS-1:0] key_release_o,
  output logic                          frame_done_o,
  output logic [NUM_PADS-1:0]           any_key_o
);

  localparam int KEYS_PER_PAD = ROWS * COLS;
  localparam int DWELL_W      = $clog2(SCAN_DIV);
  localparam int ROW_W        = $clog2(ROWS);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);

  // --------------------------------------------------------------------------
  // Column synchronisers (preset high = idle, nothing pressed)
  // --------------------------------------------------------------------------
  logic [NUM_PADS*COLS-1:0] col_meta_q;
  logic [NUM_PADS*COLS-1:0] col_sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= col_i;
      col_sync_q <= col_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Row sequencer
  // --------------------------------------------------------------------------
  logic [DWELL_W-1:0]       dwell_q, dwell_d;
  logic [ROW_W-1:0]         row_idx_q, row_idx_d;
  logic                     run_q;
  logic [NUM_PADS*ROWS-1:0] row_q, row_d;
  logic                     frame_upd_q, frame_upd_d;
  logic                     row_sample;

  // run_q marks that rows were already being driven in the previous cycle.
  // The first enabled cycle only loads row_q, so every dwell of row 0 --
  // including the first after reset or re-enable -- is a full SCAN_DIV long.
  always_comb begin
    dwell_d     = dwell_q;
    row_idx_d   = row_idx_q;
    frame_upd_d = 1'b0;
    row_sample  = 1'b0;
    if (!scan_en_i) begin
      dwell_d   = '0;
      row_idx_d = '0;
    end else if (run_q) begin
      if (dwell_q == DWELL_LAST) begin
        row_sample = 1'b1;
        dwell_d    = '0;
        if (row_idx_q == ROW_LAST) begin
          row_idx_d   = '0;
          frame_upd_d = 1'b1;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
        end
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Row drive is registered from the next row index so the pins change on
  // the same edge as the dwell counter restarts.
  always_comb begin
    row_d = '1;
    if (scan_en_i) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int r = 0; r < ROWS; r++) begin
          if (row_idx_d == ROW_W'(r)) begin
            row_d[p*ROWS + r] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q     <= '0;
      row_idx_q   <= '0;
      run_q       <= 1'b0;
      row_q       <= '1;
      frame_upd_q <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      run_q       <= scan_en_i;
      row_q       <= row_d;
      frame_upd_q <= frame_upd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame sample and per-key debounce cells
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int KB = key_bit(p, r, c, ROWS, COLS);

        logic smp_q;

        // Disabling scanning drops any partially collected frame.
        always_ff @(posedge clk_i) begin
          if (rst_i || !scan_en_i) begin
            smp_q <= 1'b0;
          end else if (row_sample && (row_idx_q == ROW_W'(r))) begin
            smp_q <= ~col_sync_q[p*COLS + c];
          end
        end

        keypad_key_debounce #(
          .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_cell (
          .clk_i     (clk_i),
          .rst_i     (rst_i),
          .upd_i     (frame_upd_q),
          .sample_i  (smp_q),
          .state_o   (key_state_o[KB]),
          .press_o   (key_press_o[KB]),
          .release_o (key_release_o[KB])
        );
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-pad activity flag, aligned with the press/release pulses
  // --------------------------------------------------------------------------
  logic [NUM_PADS-1:0] any_key_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      any_key_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        any_key_q[p] <= |key_state_o[p*KEYS_PER_PAD +: KEYS_PER_PAD];
      end
    end
  end

  assign row_o        = row_q;
  assign frame_done_o = frame_upd_q;
  assign any_key_o    = any_key_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_matrix_scanner
// Purpose : Self-checking bench for keypad_matrix_scanner (2 pads, 4x4,
//           SCAN_DIV=8, DEBOUNCE_SCANS=3). A behavioural keypad drives the
//           columns from row_o; expected key events are queued when keys
//           change and compared against the DUT's pulses by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int NP = 2;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NK = NP * NR * NC;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          scan_en_i;
  logic [NP*NR-1:0] row_o;
  logic [NP*NC-1:0] col_i;
  logic [NK-1:0] key_state_o, key_press_o, key_release_o;
  logic          frame_done_o;
  logic [NP-1:0] any_key_o;

  logic [NK-1:0] keys_held;   // behavioural keypad contacts, 1 = closed
  int            n_checks = 0;
  int            n_fail   = 0;
  int            fd_cnt   = 0;
  int            cyc      = 0;
  int            exp_q[$]; // packed event: frame*256 + press*128 + bit

  keypad_matrix_scanner #(
    .NUM_PADS(NP), .ROWS(NR), .COLS(NC), .SCAN_DIV(8), .DEBOUNCE_SCANS(3)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .scan_en_i    (scan_en_i),
    .row_o        (row_o),
    .col_i        (col_i),
    .key_state_o  (key_state_o),
    .key_press_o  (key_press_o),
    .key_release_o(key_release_o),
    .frame_done_o (frame_done_o),
    .any_key_o    (any_key_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // Closed contact pulls its column low while its row is driven low.
  always_comb begin
    col_i = '1;
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          if (keys_held[p*NR*NC + r*NC + c] && !row_o[p*NR + r])
            col_i[p*NC + c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: count frames and match every pulse against the scoreboard.
  always @(negedge clk_i) begin
    int obs;
    int e;
    if (!rst_i) begin
      if (frame_done_o) fd_cnt++;
      for (int b = 0; b < NK; b++) begin
        if (key_press_o[b] || key_release_o[b]) begin
          obs = fd_cnt * 256 + (key_press_o[b] ? 128 : 0) + b;
          if (exp_q.size() == 0) begin
            check("sb_unexpected", obs, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_event", obs, e);
          end
          check("pulse_vs_state", {31'd0, key_state_o[b]}, {31'd0, key_press_o[b]});
        end
      end
    end
  end

  task automatic push_evt(input int frame, input bit press, input int b);
    exp_q.push_back(frame * 256 + (press ? 128 : 0) + b);
  endtask

  // Returns #1 after the negedge where frame_done_o was seen.
  task automatic wait_fd();
    int t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!frame_done_o && t < 100);
    if (!frame_done_o) check("timeout_frame_done", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_frames_until(input int target);
    int g = 0;
    while (fd_cnt < target && g < 20) begin
      wait_fd();
      g++;
    end
    if (fd_cnt < target) check("timeout_frames", fd_cnt, target);
  endtask

  // Waits for row_o to differ from prev; returns new value and cycle stamp.
  task automatic wait_row_change(input logic [7:0] prev, output logic [7:0] now, output int t);
    int g = 0;
    do begin
      @(negedge clk_i);
      g++;
    end while (row_o == prev && g < 40);
    if (row_o == prev) check("timeout_row", {24'd0, row_o}, 32'hFFFF_FFFF);
    now = row_o;
    t   = cyc;
  endtask

  initial begin
    logic [7:0] rv, rexp;
    int t, t_last, n;

    rst_i     = 1'b1;
    scan_en_i = 1'b1;
    keys_held = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_row", {24'd0, row_o}, 32'h0000_00FF);
    check("rst_state", key_state_o, 32'd0);
    check("rst_fd", {31'd0, frame_done_o}, 32'd0);
    check("rst_any", {30'd0, any_key_o}, 32'd0);
    rst_i = 1'b0;

    // 1. Idle scan: row walk, dwell length, frame period
    rv = 8'hFF;
    t_last = 0;
    for (int i = 0; i < 9; i++) begin
      wait_row_change(rv, rv, t);
      rexp = 8'hFF & ~(8'h11 << (i % 4));
      check("row_pattern", {24'd0, rv}, {24'd0, rexp});
      if (i > 0) check("row_dwell", t - t_last, 32'd8);
      t_last = t;
    end
    wait_fd();
    t_last = cyc;
    wait_fd();
    check("frame_period", cyc - t_last, 32'd32);
    check("idle_state", key_state_o, 32'd0);

    // 2. Pad0 r1c2 press then release
    wait_fd();
    n = fd_cnt;
    keys_held[6] = 1'b1;
    push_evt(n + 3, 1'b1, 6);
    wait_frames_until(n + 4);
    check("held_r1c2", {31'd0, key_state_o[6]}, 32'd1);
    check("any_pad0", {30'd0, any_key_o}, 32'd1);
    n = fd_cnt;
    keys_held[6] = 1'b0;
    push_evt(n + 3, 1'b0, 6);
    wait_frames_until(n + 4);
    check("released_r1c2", {31'd0, key_state_o[6]}, 32'd0);

    // 3. Pad1 r3c0 glitch for exactly two frames
    wait_fd();
    n = fd_cnt;
    keys_held[28] = 1'b1;
    wait_frames_until(n + 2);
    keys_held[28] = 1'b0;
    wait_frames_until(n + 6);
    check("glitch_state", key_state_o, 32'd0);

    // 4. Simultaneous keys on both pads
    n = fd_cnt;
    keys_held[0]  = 1'b1;
    keys_held[27] = 1'b1;
    push_evt(n + 3, 1'b1, 0);
    push_evt(n + 3, 1'b1, 27);
    wait_frames_until(n + 4);
    check("dual_state", key_state_o, 32'h0800_0001);
    check("dual_any", {30'd0, any_key_o}, 32'd3);
    n = fd_cnt;
    keys_held[0]  = 1'b0;
    keys_held[27] = 1'b0;
    push_evt(n + 3, 1'b0, 0);
    push_evt(n + 3, 1'b0, 27);
    wait_frames_until(n + 4);
    check("dual_any_clear", {30'd0, any_key_o}, 32'd0);

    // 5. Scan disabled mid-debounce; the count must survive
    n = fd_cnt;
    keys_held[6] = 1'b1;
    wait_frames_until(n + 1);
    repeat (12) @(negedge clk_i);
    #1;
    scan_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("dis_rows", {24'd0, row_o}, 32'h0000_00FF);
    repeat (20) @(negedge clk_i);
    check("dis_no_frames", fd_cnt, n + 1);
    check("dis_state_held", {31'd0, key_state_o[6]}, 32'd0);
    #1;
    scan_en_i = 1'b1;
    push_evt(n + 3, 1'b1, 6);
    wait_frames_until(n + 4);
    check("resume_state", {31'd0, key_state_o[6]}, 32'd1);

    // 6. Reset while a key is held
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mrst_state", key_state_o, 32'd0);
    check("mrst_press", key_press_o, 32'd0);
    check("mrst_release", key_release_o, 32'd0);
    check("mrst_any", {30'd0, any_key_o}, 32'd0);
    check("mrst_row", {24'd0, row_o}, 32'h0000_00FF);
    keys_held = '0;
    repeat (2) @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    wait_row_change(8'hFF, rv, t_last);
    check("restart_row0", {24'd0, rv}, 32'h0000_00EE);
    wait_row_change(rv, rv, t);
    check("restart_row1", {24'd0, rv}, 32'h0000_00DD);
    check("restart_dwell", t - t_last, 32'd8);
    n = fd_cnt;
    wait_frames_until(n + 4);
    check("final_state", key_state_o, 32'd0);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
